// File: rtl/johnson_counter_gen_pkg.sv
// Shared definitions for the Johnson counter family: direction encoding and
// the phase-width helper used by the counter, its interface and its decoder.
package johnson_pkg;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    function automatic int johnson_phase_w(input int width);
        return $clog2(2 * width);
    endfunction

endpackage

// File: rtl/johnson_counter_gen_if.sv
// Control/status bundle of the Johnson counter; master drives controls, slave is the counter.
interface johnson_counter_gen_if
    import johnson_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int PW    = johnson_phase_w(WIDTH)
);
    logic             prst;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             dir;
    logic [WIDTH-1:0] out;
    logic [PW-1:0]    phase;
    logic [2*WIDTH-1:0] dec;
    logic             tc;
    logic             err;

    modport master (
        output prst, load, load_val, en, dir,
        input  out, phase, dec, tc, err
    );

    modport slave (
        input  prst, load, load_val, en, dir,
        output out, phase, dec, tc, err
    );
endinterface

// File: rtl/johnson_counter_gen_decode.sv
// Combinational Johnson-state decoder: legality, one-hot phase decode and binary phase.
module johnson_decode
    import johnson_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int PW    = johnson_phase_w(WIDTH)
) (
    input  logic [WIDTH-1:0]   i_out,
    output logic               o_legal,
    output logic [PW-1:0]      o_phase,
    output logic [2*WIDTH-1:0] o_dec
);
    logic [WIDTH-1:0]   w_inc;
    logic [WIDTH-1:0]   w_inv;
    logic [WIDTH-1:0]   w_inv_inc;
    logic [2*WIDTH-1:0] w_raw_dec;

    // Legal states are a run of ones anchored at bit 0, or a run of zeros anchored at bit 0.
    assign w_inc     = i_out + WIDTH'(1);
    assign w_inv     = ~i_out;
    assign w_inv_inc = w_inv + WIDTH'(1);
    assign o_legal   = ((i_out & w_inc) == '0) || ((w_inv & w_inv_inc) == '0);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dec
            if (gi == 0) begin : g_ends
                assign w_raw_dec[0]     = ~i_out[WIDTH-1] & ~i_out[0];
                assign w_raw_dec[WIDTH] =  i_out[WIDTH-1] &  i_out[0];
            end else begin : g_mid
                assign w_raw_dec[gi]         =  i_out[gi-1] & ~i_out[gi];
                assign w_raw_dec[WIDTH + gi] = ~i_out[gi-1] &  i_out[gi];
            end
        end
    endgenerate

    assign o_dec = o_legal ? w_raw_dec : '0;

    always_comb begin
        o_phase = '0;
        for (int k = 0; k < 2 * WIDTH; k++) begin
            if (o_dec[k]) begin
                o_phase = o_phase | PW'(k);
            end
        end
    end
endmodule

// File: rtl/johnson_counter_gen.sv
// Parametrised Johnson counter: priority next-state mux, state register and tc/err pulse flags.
module johnson_counter_gen
    import johnson_pkg::*;
#(
    parameter int               WIDTH      = 4,
    parameter logic [WIDTH-1:0] PRESET_VAL = '1
) (
    input  logic                  clk,
    input  logic                  clr,
    johnson_counter_gen_if.slave  bus
);
    localparam int PW = johnson_phase_w(WIDTH);
    localparam int N  = 2 * WIDTH;

    function automatic bit preset_is_legal(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] inc;
        logic [WIDTH-1:0] inv;
        logic [WIDTH-1:0] inv_inc;
        inc     = v + WIDTH'(1);
        inv     = ~v;
        inv_inc = inv + WIDTH'(1);
        return ((v & inc) == '0) || ((inv & inv_inc) == '0);
    endfunction

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("johnson_counter_gen: WIDTH must be at least 2");
        end
        if (!preset_is_legal(PRESET_VAL)) begin : g_bad_preset
            $error("johnson_counter_gen: PRESET_VAL is not a legal Johnson state");
        end
    endgenerate

    logic [WIDTH-1:0]   r_out;
    logic               r_tc;
    logic               r_err;
    logic [WIDTH-1:0]   w_out_next;
    logic               w_tc_next;
    logic               w_err_next;
    logic               w_legal;
    logic [PW-1:0]      w_phase;
    logic [2*WIDTH-1:0] w_dec;

    johnson_decode #(
        .WIDTH (WIDTH),
        .PW    (PW)
    ) u_decode (
        .i_out   (r_out),
        .o_legal (w_legal),
        .o_phase (w_phase),
        .o_dec   (w_dec)
    );

    // clr is handled in the register itself; everything below is the non-reset priority chain.
    always_comb begin
        w_out_next = r_out;
        w_tc_next  = 1'b0;
        w_err_next = 1'b0;
        if (bus.prst) begin
            w_out_next = PRESET_VAL;
        end else if (bus.load) begin
            w_out_next = bus.load_val;
        end else if (bus.en) begin
            if (!w_legal) begin
                w_out_next = '0;
                w_err_next = 1'b1;
            end else if (bus.dir == DIR_FWD) begin
                w_out_next = {r_out[WIDTH-2:0], ~r_out[WIDTH-1]};
                w_tc_next  = (w_phase == PW'(N - 1));
            end else begin
                w_out_next = {~r_out[0], r_out[WIDTH-1:1]};
                w_tc_next  = (w_phase == PW'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_out <= '0;
            r_tc  <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_out <= w_out_next;
            r_tc  <= w_tc_next;
            r_err <= w_err_next;
        end
    end

    assign bus.out   = r_out;
    assign bus.phase = w_phase;
    assign bus.dec   = w_dec;
    assign bus.tc    = r_tc;
    assign bus.err   = r_err;
endmodule

// File: tb/tb_johnson_counter_gen.sv
// Self-checking bench: WIDTH=4 vector table, hand sequences and random run vs a phase model; WIDTH=7 up/down run.
module tb_johnson_counter_gen;
    logic clk = 1'b0;
    logic clr4 = 1'b1;
    logic clr7 = 1'b1;

    always #5 clk = ~clk;

    johnson_counter_gen_if #(.WIDTH(4)) bus4 ();
    johnson_counter_gen_if #(.WIDTH(7)) bus7 ();

    johnson_counter_gen #(.WIDTH(4)) dut4 (.clk(clk), .clr(clr4), .bus(bus4));
    johnson_counter_gen #(.WIDTH(7)) dut7 (.clk(clk), .clr(clr7), .bus(bus7));

    int n_pass  = 0;
    int n_total = 0;

    logic [3:0] m4_out = 4'h0;
    logic       m4_tc  = 1'b0;
    logic       m4_err = 1'b0;

    typedef struct {
        logic       clr;
        logic       prst;
        logic       load;
        logic [3:0] lv;
        logic       en;
        logic       dir;
        logic [3:0] eo;
        logic       etc;
        logic       eerr;
    } vec_t;

    vec_t vq[$];

    // Johnson value at phase k, built from the "run of ones" description.
    function automatic logic [15:0] jval(input int w, input int k);
        logic [15:0] mask;
        mask = 16'((32'd1 << w) - 1);
        if (k <= w) return 16'((32'd1 << k) - 1);
        return mask ^ 16'((32'd1 << (k - w)) - 1);
    endfunction

    function automatic int jidx(input int w, input logic [15:0] v);
        for (int k = 0; k < 2 * w; k++) begin
            if (jval(w, k) == v) return k;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model4_step();
        int k;
        logic [15:0] t;
        m4_tc  = 1'b0;
        m4_err = 1'b0;
        if (clr4) m4_out = 4'h0;
        else if (bus4.prst) m4_out = 4'hF;
        else if (bus4.load) m4_out = bus4.load_val;
        else if (bus4.en) begin
            k = jidx(4, 16'(m4_out));
            if (k < 0) begin
                m4_out = 4'h0;
                m4_err = 1'b1;
            end else begin
                k = bus4.dir ? (k + 7) % 8 : (k + 1) % 8;
                t = jval(4, k);
                m4_out = t[3:0];
                m4_tc  = (k == 0);
            end
        end
    endtask

    task automatic tick();
        model4_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check4(input string tag);
        int k;
        k = jidx(4, 16'(m4_out));
        chk({tag, ".out"},   32'(bus4.out),   32'(m4_out));
        chk({tag, ".tc"},    32'(bus4.tc),    32'(m4_tc));
        chk({tag, ".err"},   32'(bus4.err),   32'(m4_err));
        chk({tag, ".phase"}, 32'(bus4.phase), (k < 0) ? 32'd0 : 32'(k));
        chk({tag, ".dec"},   32'(bus4.dec),   (k < 0) ? 32'd0 : (32'd1 << k));
    endtask

    task automatic set4(input logic c, input logic p, input logic l, input logic [3:0] lv,
                        input logic e, input logic d);
        clr4 = c; bus4.prst = p; bus4.load = l; bus4.load_val = lv; bus4.en = e; bus4.dir = d;
    endtask

    task automatic add(input logic c, input logic p, input logic l, input logic [3:0] lv,
                       input logic e, input logic d, input logic [3:0] eo, input logic etc,
                       input logic eerr);
        vec_t v;
        v.clr = c; v.prst = p; v.load = l; v.lv = lv; v.en = e; v.dir = d;
        v.eo = eo; v.etc = etc; v.eerr = eerr;
        vq.push_back(v);
    endtask

    initial begin
        int k;
        int p;
        logic [15:0] t;
        logic [3:0] seq [8];
        seq = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};

        bus7.prst = 1'b0; bus7.load = 1'b0; bus7.load_val = '0; bus7.en = 1'b0; bus7.dir = 1'b0;
        set4(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);

        // clr, then 16 forward advances, then the directed corner cases
        add(1, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 8; i++) add(0, 0, 0, 4'h0, 1, 0, seq[i], (i == 7), 0);
        add(0, 0, 1, 4'h7, 0, 0, 4'h7, 0, 0);
        add(0, 0, 0, 4'h0, 1, 1, 4'h3, 0, 0);
        add(0, 0, 0, 4'h0, 1, 1, 4'h1, 0, 0);
        add(0, 0, 0, 4'h0, 1, 1, 4'h0, 1, 0);
        add(0, 0, 0, 4'h0, 1, 1, 4'h8, 0, 0);
        add(0, 0, 1, 4'h5, 0, 0, 4'h5, 0, 0);
        add(0, 0, 0, 4'h0, 1, 0, 4'h0, 0, 1);
        add(0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0);
        add(0, 1, 1, 4'h3, 1, 0, 4'hF, 0, 0);
        add(1, 0, 1, 4'h5, 1, 0, 4'h0, 0, 0);
        add(0, 0, 1, 4'hE, 1, 1, 4'hE, 0, 0);
        add(0, 0, 0, 4'h0, 1, 1, 4'hF, 0, 0);
        add(0, 0, 1, 4'h8, 0, 0, 4'h8, 0, 0);
        add(0, 0, 1, 4'h0, 1, 0, 4'h0, 0, 0);
        add(0, 0, 0, 4'h0, 1, 1, 4'h8, 0, 0);

        foreach (vq[i]) begin
            set4(vq[i].clr, vq[i].prst, vq[i].load, vq[i].lv, vq[i].en, vq[i].dir);
            tick();
            k = jidx(4, 16'(vq[i].eo));
            chk("tbl.out",   32'(bus4.out),   32'(vq[i].eo));
            chk("tbl.tc",    32'(bus4.tc),    32'(vq[i].etc));
            chk("tbl.err",   32'(bus4.err),   32'(vq[i].eerr));
            chk("tbl.phase", 32'(bus4.phase), (k < 0) ? 32'd0 : 32'(k));
            chk("tbl.dec",   32'(bus4.dec),   (k < 0) ? 32'd0 : (32'd1 << k));
            $display("vec %0d: out=%b phase=%0d tc=%0d err=%0d", i, bus4.out, bus4.phase, bus4.tc, bus4.err);
        end

        // illegal value held with en=0: reported only through phase/dec
        set4(0, 0, 1, 4'h5, 0, 0);
        tick();
        set4(0, 0, 0, 4'h0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check4("hold_illegal");
            chk("hold_illegal.raw", 32'(bus4.out), 32'h5);
            $display("hold_illegal %0d: out=%b phase=%0d dec=%b", i, bus4.out, bus4.phase, bus4.dec);
        end

        // hold at phase 5 for 10 cycles
        set4(0, 0, 1, 4'hE, 0, 0);
        tick();
        set4(0, 0, 0, 4'h0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check4("hold5");
            chk("hold5.phase", 32'(bus4.phase), 32'd5);
            $display("hold5 %0d: out=%b phase=%0d", i, bus4.out, bus4.phase);
        end

        // randomized traffic against the phase-level model
        for (int i = 0; i < 400; i++) begin
            logic [3:0] lv;
            if ($urandom_range(1, 0) == 1) begin
                t  = jval(4, int'($urandom_range(7, 0)));
                lv = t[3:0];
            end else begin
                lv = 4'($urandom_range(15, 0));
            end
            set4($urandom_range(99, 0) < 2, $urandom_range(99, 0) < 3, $urandom_range(99, 0) < 8,
                 lv, $urandom_range(99, 0) < 70, 1'($urandom_range(1, 0)));
            tick();
            check4("rand");
            $display("rand %0d: out=%b tc=%0d err=%0d", i, bus4.out, bus4.tc, bus4.err);
        end
        set4(0, 0, 0, 4'h0, 0, 0);

        // WIDTH=7: reset state, then up/down run against a modulo-14 counter
        tick();
        clr7 = 1'b0;
        chk("w7.rst.out",   32'(bus7.out),   32'd0);
        chk("w7.rst.phase", 32'(bus7.phase), 32'd0);
        chk("w7.rst.dec",   32'(bus7.dec),   32'd1);
        chk("w7.rst.tc",    32'(bus7.tc),    32'd0);
        chk("w7.rst.err",   32'(bus7.err),   32'd0);
        p = 0;
        for (int c = 0; c < 50; c++) begin
            bus7.en  = 1'b1;
            bus7.dir = ((c / 3) % 2 == 1);
            tick();
            p = bus7.dir ? (p + 13) % 14 : (p + 1) % 14;
            t = jval(7, p);
            chk("w7.phase", 32'(bus7.phase), 32'(p));
            chk("w7.out",   32'(bus7.out),   32'(t[6:0]));
            chk("w7.dec",   32'(bus7.dec),   32'd1 << p);
            chk("w7.tc",    32'(bus7.tc),    32'(p == 0));
            chk("w7.err",   32'(bus7.err),   32'd0);
            $display("w7 %0d: dir=%0d out=%b phase=%0d tc=%0d", c, bus7.dir, bus7.out, bus7.phase, bus7.tc);
        end
        bus7.en   = 1'b0;
        bus7.prst = 1'b1;
        tick();
        bus7.prst = 1'b0;
        chk("w7.prst.out",   32'(bus7.out),   32'h7F);
        chk("w7.prst.phase", 32'(bus7.phase), 32'd7);
        chk("w7.prst.tc",    32'(bus7.tc),    32'd0);
        $display("w7 prst: out=%b phase=%0d", bus7.out, bus7.phase);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
